// File: rtl/vpifo_pop_scheduler.sv
// Purpose: weighted round-robin pop scheduler that tracks per-tree occupancy and issues pops to the vPIFO task generator.
// Latency: a push at edge k makes o_pop high in cycle k+2; pops are spaced by at least POP_GAP+1 cycles.
// Backpressure: one pop outstanding at a time; it waits for i_pop_out, or gives up after TIMEOUT WAIT cycles.
module vpifo_pop_scheduler #(
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int PTW           = 16,
  parameter int MTW           = $clog2(TREE_NUM),
  parameter int CNT_W         = 16,
  parameter int WEIGHT_W      = 4,
  parameter int POP_GAP       = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic                         i_clk,
  input  logic                         i_arst_n,
  input  logic                         i_enable,
  input  logic                         i_push,
  input  logic [TREE_NUM_BITS-1:0]     i_push_tree_id,
  input  logic [TREE_NUM*WEIGHT_W-1:0] i_weight,
  output logic                         o_pop,
  output logic [TREE_NUM_BITS-1:0]     o_pop_tree_id,
  input  logic                         i_pop_out,
  input  logic [MTW+PTW-1:0]           i_pop_data,
  output logic [MTW+PTW-1:0]           o_last_pop_data,
  output logic [TREE_NUM-1:0]          o_nonempty,
  output logic [CNT_W-1:0]             o_pop_count,
  output logic                         o_overflow,
  output logic                         o_timeout
);

  // gap_cnt never needs to count past TIMEOUT-1
  localparam int GAP_W = $clog2(TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(POP_GAP - 1);
  localparam logic [GAP_W-1:0] TOUT_LAST = GAP_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OCC_MAX   = '1;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t                    state, state_next;
  logic [CNT_W-1:0]          occ      [TREE_NUM];
  logic [CNT_W-1:0]          occ_next [TREE_NUM];
  logic [TREE_NUM-1:0]       occ_nz;
  logic [TREE_NUM-1:0]       push_hit, issue_hit;
  logic [TREE_NUM_BITS-1:0]  cur, scan_tree, sel_tree;
  logic [WEIGHT_W-1:0]       credit, scan_weight, sel_credit;
  logic [GAP_W-1:0]          gap_cnt;
  logic                      done_seen, found;
  logic                      issue, complete, tout_hit, ovf_hit;

  // Wrapping tree index: base + off modulo TREE_NUM
  function automatic logic [TREE_NUM_BITS-1:0] wrap_add(input logic [TREE_NUM_BITS-1:0] base, input int off);
    return TREE_NUM_BITS'((int'(base) + off) % TREE_NUM);
  endfunction

  // Non-empty view of the registered occupancy; all decisions are made from this
  always_comb begin
    occ_nz = '0;
    for (int n = 0; n < TREE_NUM; n++) occ_nz[n] = (occ[n] != '0);
  end

  // Tree choice: stay on cur while it has credit, else first non-empty tree after cur (cur itself last)
  always_comb begin
    found     = 1'b0;
    scan_tree = cur;
    for (int k = 1; k <= TREE_NUM; k++) begin
      if (!found && occ_nz[wrap_add(cur, k)]) begin
        found     = 1'b1;
        scan_tree = wrap_add(cur, k);
      end
    end
    scan_weight = i_weight[int'(scan_tree)*WEIGHT_W +: WEIGHT_W];
    if (occ_nz[cur] && credit != '0) begin
      sel_tree   = cur;
      sel_credit = credit - WEIGHT_W'(1);
    end else begin
      sel_tree   = scan_tree;
      // zero weight behaves as a quantum of one
      sel_credit = (scan_weight == '0) ? '0 : scan_weight - WEIGHT_W'(1);
    end
  end

  // FSM next state: issue from IDLE, leave WAIT on completion past the gap or on timeout
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    complete   = 1'b0;
    tout_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_enable && (occ_nz != '0)) begin
          issue      = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        complete = i_pop_out && !done_seen;
        if (done_seen || i_pop_out) begin
          if (gap_cnt >= GAP_LAST) state_next = ST_IDLE;
        end else if (gap_cnt == TOUT_LAST) begin
          tout_hit   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Occupancy update: a push and an issue to the same tree cancel; a saturated push is dropped
  always_comb begin
    push_hit  = '0;
    issue_hit = '0;
    ovf_hit   = 1'b0;
    if (i_push) push_hit[i_push_tree_id] = 1'b1;
    if (issue)  issue_hit[sel_tree]      = 1'b1;
    for (int n = 0; n < TREE_NUM; n++) begin
      occ_next[n] = occ[n];
      if (push_hit[n] && !issue_hit[n]) begin
        if (occ[n] == OCC_MAX) ovf_hit = 1'b1;
        else                   occ_next[n] = occ[n] + CNT_W'(1);
      end else if (issue_hit[n] && !push_hit[n]) begin
        occ_next[n] = occ[n] - CNT_W'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state <= ST_IDLE;
    else           state <= state_next;
  end

  // Occupancy counters, registered non-empty flags and sticky overflow
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int n = 0; n < TREE_NUM; n++) occ[n] <= '0;
      o_nonempty <= '0;
      o_overflow <= 1'b0;
    end else begin
      for (int n = 0; n < TREE_NUM; n++) begin
        occ[n]        <= occ_next[n];
        o_nonempty[n] <= (occ_next[n] != '0);
      end
      if (ovf_hit) o_overflow <= 1'b1;
    end
  end

  // Issue side: round-robin pointer, credit, pop strobe and WAIT bookkeeping
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cur           <= '0;
      credit        <= '0;
      o_pop         <= 1'b0;
      o_pop_tree_id <= '0;
      gap_cnt       <= '0;
      done_seen     <= 1'b0;
    end else begin
      o_pop <= issue;
      if (issue) begin
        cur           <= sel_tree;
        credit        <= sel_credit;
        o_pop_tree_id <= sel_tree;
        gap_cnt       <= '0;
        done_seen     <= 1'b0;
      end else if (state == ST_WAIT) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
        if (complete) done_seen <= 1'b1;
      end
    end
  end

  // Completion side: pop counter, captured data and sticky timeout
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_pop_count     <= '0;
      o_last_pop_data <= '0;
      o_timeout       <= 1'b0;
    end else begin
      if (complete) begin
        o_pop_count     <= o_pop_count + CNT_W'(1);
        o_last_pop_data <= i_pop_data;
      end
      if (tout_hit) o_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vpifo_pop_scheduler.sv
// Bench for vpifo_pop_scheduler: directed table, hand sequences and a randomized run against a reference model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// The responder answers each o_pop with i_pop_out after a programmable delay.
module tb_vpifo_pop_scheduler;
  localparam int TN = 4, PTW = 16, MTW = 2, CNT_W = 16, WW = 4, POP_GAP = 4, TIMEOUT = 64;

  logic clk = 1'b0;
  logic arst_n, enable, push, pop, pop_out, overflow, timeout;
  logic [1:0]  push_tree_id, pop_tree_id;
  logic [15:0] weight, pop_count;
  logic [17:0] pop_data, last_pop_data;
  logic [3:0]  nonempty;

  always #5 clk = ~clk;

  vpifo_pop_scheduler #(.TREE_NUM(TN), .PTW(PTW), .MTW(MTW), .CNT_W(CNT_W), .WEIGHT_W(WW),
                        .POP_GAP(POP_GAP), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_arst_n(arst_n), .i_enable(enable), .i_push(push),
    .i_push_tree_id(push_tree_id), .i_weight(weight), .o_pop(pop), .o_pop_tree_id(pop_tree_id),
    .i_pop_out(pop_out), .i_pop_data(pop_data), .o_last_pop_data(last_pop_data),
    .o_nonempty(nonempty), .o_pop_count(pop_count), .o_overflow(overflow), .o_timeout(timeout));

  int n_vec = 0, n_bad = 0, cyc = 0;
  int resp_en = 0, resp_dly = 1, resp_cd = -1, resp_rand = 0;
  logic [17:0] resp_data = '0;
  int pop_tree_q[$], pop_cyc_q[$];
  int tout_cyc = -1;

  // Reference model state (spec-level: integer counts, pointer, credit, earliest next decision)
  bit mdl_on = 0;
  int m_occ[4];
  int m_cur, m_credit, m_last_pop, m_cnt;
  logic [17:0] m_data;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] wt;
    int          t0;
    int          t1;
    logic [3:0]  ne;
  } vec_t;
  vec_t tbl[6];
  int wrr_exp[16] = '{1, 1, 2, 3, 0, 1, 1, 2, 3, 0, 2, 3, 0, 2, 3, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    foreach (m_occ[i]) m_occ[i] = 0;
    m_cur = 0; m_credit = 0; m_last_pop = -100; m_cnt = 0; m_data = '0;
  endtask

  // One clock: model predicts, edge, monitor/responder update, model compares
  task automatic cycle();
    bit exp_pop; int exp_tree; bit any; bit fnd; int w;
    bit was_push; int was_tree; bit was_po; logic [17:0] was_pd; logic [3:0] m_ne;
    exp_pop = 0; exp_tree = 0; any = 0;
    if (mdl_on) begin
      foreach (m_occ[i]) if (m_occ[i] > 0) any = 1;
      exp_pop = enable && any && (cyc >= m_last_pop + POP_GAP);
      if (exp_pop) begin
        if (m_occ[m_cur] > 0 && m_credit > 0) begin
          exp_tree = m_cur;
          m_credit--;
        end else begin
          fnd = 0;
          for (int k = 1; k <= 4; k++) begin
            if (!fnd && m_occ[(m_cur + k) % 4] > 0) begin
              fnd = 1;
              exp_tree = (m_cur + k) % 4;
            end
          end
          m_cur = exp_tree;
          w = int'(weight[exp_tree*4 +: 4]);
          m_credit = (w == 0) ? 0 : w - 1;
        end
      end
    end
    was_push = push; was_tree = int'(push_tree_id); was_po = pop_out; was_pd = pop_data;
    @(posedge clk); #1; cyc++;
    if (timeout && tout_cyc < 0) tout_cyc = cyc;
    if (pop) begin
      pop_tree_q.push_back(int'(pop_tree_id));
      pop_cyc_q.push_back(cyc);
      if (resp_rand != 0) resp_data = 18'($urandom);
      if (resp_en != 0) resp_cd = resp_dly;
    end
    if (mdl_on) begin
      check("rand_pop_strobe", pop, exp_pop);
      if (exp_pop) begin
        check("rand_pop_tree", pop_tree_id, exp_tree);
        m_occ[exp_tree]--;
        m_last_pop = cyc;
      end
      if (was_push) m_occ[was_tree]++;
      if (was_po) begin
        m_cnt++;
        m_data = was_pd;
      end
      for (int i = 0; i < 4; i++) m_ne[i] = (m_occ[i] != 0);
      check("rand_nonempty", nonempty, m_ne);
      check("rand_pop_count", pop_count, m_cnt & 16'hFFFF);
      check("rand_last_data", last_pop_data, m_data);
    end
    push = 1'b0;
    if (resp_cd == 0) begin
      pop_out  = 1'b1;
      pop_data = resp_data;
    end else begin
      pop_out = 1'b0;
    end
    if (resp_cd >= 0) resp_cd--;
  endtask

  task automatic do_push(input int t);
    push = 1'b1;
    push_tree_id = 2'(t);
    cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pop"}, pop, 0);
    check({tag, "_tree_id"}, pop_tree_id, 0);
    check({tag, "_last_data"}, last_pop_data, 0);
    check({tag, "_pop_count"}, pop_count, 0);
    check({tag, "_nonempty"}, nonempty, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  task automatic do_reset(input bit chk);
    arst_n = 1'b0; enable = 1'b0; push = 1'b0; push_tree_id = '0;
    pop_out = 1'b0; pop_data = '0; resp_cd = -1; resp_en = 0; resp_rand = 0;
    #1;
    if (chk) check_all_zero("in_reset");
    repeat (3) @(posedge clk);
    #1;
    arst_n = 1'b1;
    pop_tree_q.delete();
    pop_cyc_q.delete();
    tout_cyc = -1;
    model_clear();
  endtask

  task automatic wait_pops(input int n, input bit stop, input int budget);
    for (int i = 0; i < budget && pop_tree_q.size() < n; i++) begin
      cycle();
      if (stop && pop_tree_q.size() >= n) enable = 1'b0;
    end
    check("pops_seen", pop_tree_q.size(), n);
  endtask

  initial begin
    int p;
    arst_n = 1'b0; enable = 1'b0; push = 1'b0; push_tree_id = '0;
    weight = 16'h1111; pop_out = 1'b0; pop_data = '0;
    model_clear();

    // Reset: everything zero during and after reset, and no pop with nothing pushed
    do_reset(1);
    check_all_zero("after_reset");
    enable = 1'b1;
    repeat (10) cycle();
    check("reset_no_pop", pop_tree_q.size(), 0);
    check_all_zero("idle_enabled");

    // First two pops from reset for several occupancy/weight patterns (2 pushes per marked tree)
    tbl[0] = '{mask: 4'b0001, wt: 16'h1111, t0: 0, t1: 0, ne: 4'b0000};
    tbl[1] = '{mask: 4'b1000, wt: 16'h2111, t0: 3, t1: 3, ne: 4'b0000};
    tbl[2] = '{mask: 4'b0101, wt: 16'h1111, t0: 2, t1: 0, ne: 4'b0101};
    tbl[3] = '{mask: 4'b0110, wt: 16'h1101, t0: 1, t1: 2, ne: 4'b0110};
    tbl[4] = '{mask: 4'b0110, wt: 16'h1131, t0: 1, t1: 1, ne: 4'b0100};
    tbl[5] = '{mask: 4'b1001, wt: 16'h1111, t0: 3, t1: 0, ne: 4'b1001};
    for (int r = 0; r < 6; r++) begin
      do_reset(0);
      weight = tbl[r].wt;
      for (int t = 0; t < 4; t++) if (tbl[r].mask[t]) begin do_push(t); do_push(t); end
      resp_en = 1; resp_dly = 1; resp_data = 18'(r + 1);
      enable = 1'b1;
      wait_pops(2, 1, 40);
      if (pop_tree_q.size() >= 2) begin
        check($sformatf("tbl%0d_first_tree", r), pop_tree_q[0], tbl[r].t0);
        check($sformatf("tbl%0d_second_tree", r), pop_tree_q[1], tbl[r].t1);
      end
      repeat (6) cycle();
      check($sformatf("tbl%0d_nonempty", r), nonempty, tbl[r].ne);
      check($sformatf("tbl%0d_pop_count", r), pop_count, 2);
      check($sformatf("tbl%0d_last_data", r), last_pop_data, 18'(r + 1));
    end

    // Single tree: three pops of tree 2, 5 cycles apart
    do_reset(0);
    weight = 16'h1111;
    repeat (3) do_push(2);
    resp_en = 1; resp_dly = 1; resp_data = 18'h20005;
    enable = 1'b1;
    repeat (40) cycle();
    check("single_pop_pulses", pop_tree_q.size(), 3);
    for (int i = 0; i < pop_tree_q.size(); i++) begin
      check("single_tree_id", pop_tree_q[i], 2);
      if (i > 0) check("single_spacing", pop_cyc_q[i] - pop_cyc_q[i-1], 5);
    end
    check("single_pop_count", pop_count, 3);
    check("single_last_data", last_pop_data, 18'h20005);
    check("single_nonempty", nonempty, 0);

    // Weighted round robin with tree 1 weighted 2
    do_reset(0);
    weight = 16'h1121;
    for (int r = 0; r < 4; r++) for (int t = 0; t < 4; t++) do_push(t);
    resp_en = 1; resp_dly = 1; resp_data = 18'h1ABCD;
    enable = 1'b1;
    wait_pops(16, 0, 120);
    repeat (8) cycle();
    for (int i = 0; i < pop_tree_q.size() && i < 16; i++)
      check($sformatf("wrr_order_%0d", i), pop_tree_q[i], wrr_exp[i]);
    check("wrr_pop_count", pop_count, 16);
    check("wrr_nonempty", nonempty, 0);

    // Timeout: no completion; a tree 1 entry queued meanwhile pops TIMEOUT+1 cycles later
    do_reset(0);
    weight = 16'h1111;
    do_push(0);
    enable = 1'b1;
    wait_pops(1, 0, 10);
    p = (pop_cyc_q.size() > 0) ? pop_cyc_q[0] : 0;
    repeat (3) cycle();
    do_push(1);
    wait_pops(2, 0, 90);
    check("timeout_delay", tout_cyc - p, TIMEOUT);
    if (pop_tree_q.size() >= 2) begin
      check("timeout_repop_tree", pop_tree_q[1], 1);
      check("timeout_repop_gap", pop_cyc_q[1] - p, TIMEOUT + 1);
    end
    check("timeout_sticky", timeout, 1);
    check("timeout_pop_count", pop_count, 0);
    check("timeout_nonempty0", nonempty[0], 0);

    // Push to tree 3 in the very cycle tree 3 is chosen: occupancy stays 1
    do_reset(0);
    weight = 16'h1111;
    do_push(3);
    resp_en = 1; resp_dly = 1; resp_data = 18'h30033;
    enable = 1'b1; push = 1'b1; push_tree_id = 2'd3;
    cycle();
    check("simul_pop", pop, 1);
    check("simul_tree", pop_tree_id, 3);
    check("simul_nonempty", nonempty, 4'b1000);
    enable = 1'b0;
    repeat (10) cycle();
    check("simul_nonempty_held", nonempty, 4'b1000);
    enable = 1'b1;
    repeat (12) cycle();
    check("simul_total_pops", pop_tree_q.size(), 2);
    check("simul_drained", nonempty, 0);
    check("simul_pop_count", pop_count, 2);

    // Reset two cycles into WAIT clears everything immediately, no flag, no stray pop
    do_reset(0);
    weight = 16'h1111;
    do_push(2); do_push(2);
    enable = 1'b1;
    wait_pops(1, 0, 10);
    cycle(); cycle();
    do_reset(1);
    enable = 1'b1;
    repeat (20) cycle();
    check("midrst_no_pop", pop_tree_q.size(), 0);
    check("midrst_timeout", timeout, 0);
    check("midrst_nonempty", nonempty, 0);
    resp_en = 1; resp_dly = 1; resp_data = 18'h2_0077;
    do_push(2);
    wait_pops(1, 0, 10);
    if (pop_tree_q.size() > 0) check("midrst_new_pop_tree", pop_tree_q[0], 2);

    // Randomized traffic against the reference model, then a drain
    do_reset(0);
    weight = 16'($urandom);
    mdl_on = 1;
    resp_en = 1; resp_rand = 1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) weight = 16'($urandom);
      push = ($urandom_range(0, 3) == 0);
      push_tree_id = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 7) != 0);
      resp_dly = $urandom_range(0, POP_GAP - 1);
      cycle();
    end
    enable = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      resp_dly = $urandom_range(0, POP_GAP - 1);
      cycle();
    end
    mdl_on = 0;
    check("rand_drained", nonempty, 0);
    check("rand_no_overflow", overflow, 0);
    check("rand_no_timeout", timeout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
